// File: rtl/usb_protocol.sv
// USB host transaction engine: sequences TOKEN/DATA/handshake packets with timeout and retry.
// Optional DATA0/DATA1 toggling on OUT transfers is enabled by defining USB_DATA_TOGGLE_EN.
module usb_protocol #(
    parameter logic [7:0] TIMEOUT_CYC = 8'd200,
    parameter logic [3:0] MAX_RETRY   = 4'd8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        input_ready,
    input  logic        send_in,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data_down_pro,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_err,
    output logic        free,
    output logic        bad,
    output logic        recv_ready_pro,
    output logic [63:0] data_up_pro,
    output logic        tx_start,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, HS_TX, FAIL
    } state_t;

    state_t      state, state_nxt;

    logic        send_q;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic [63:0] data_q;

    logic [3:0]  retry_cnt;
    logic [7:0]  timer;
    logic        hs_ack, hs_ack_nxt;

    logic        retry, capture, out_acked, in_done, timeout;
    logic        launch, in_wait, enter_wait;
    logic [3:0]  pid_nxt, data_pid;
    logic        send_nxt;
    logic [6:0]  addr_nxt;
    logic [3:0]  endp_nxt;

`ifdef USB_DATA_TOGGLE_EN
    logic toggle;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)
            toggle <= 1'b0;
        else if (out_acked)
            toggle <= ~toggle;
    end

    assign data_pid = toggle ? PID_DATA1 : PID_DATA0;
`else
    assign data_pid = PID_DATA0;
`endif

    // The counter reads 0 in the first wait cycle, so a wait state lasts TIMEOUT_CYC+1 cycles.
    assign timeout = (timer == TIMEOUT_CYC);
    assign in_wait = (state == WAIT_HS) || (state == WAIT_DATA);

    always_comb begin
        state_nxt  = state;
        retry      = 1'b0;
        hs_ack_nxt = hs_ack;
        capture    = 1'b0;
        out_acked  = 1'b0;
        in_done    = 1'b0;
        case (state)
            IDLE: begin
                if (input_ready)
                    state_nxt = TOKEN;
            end
            TOKEN: begin
                if (tx_done)
                    state_nxt = send_q ? WAIT_DATA : DATA_TX;
            end
            DATA_TX: begin
                if (tx_done)
                    state_nxt = WAIT_HS;
            end
            WAIT_HS: begin
                if (rx_valid) begin
                    if (!rx_err && rx_pid == PID_ACK) begin
                        state_nxt = IDLE;
                        out_acked = 1'b1;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (timeout) begin
                    retry = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        state_nxt  = HS_TX;
                        hs_ack_nxt = 1'b0;
                    end else if (rx_pid == PID_DATA0 || rx_pid == PID_DATA1) begin
                        state_nxt  = HS_TX;
                        hs_ack_nxt = 1'b1;
                        capture    = 1'b1;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (timeout) begin
                    retry = 1'b1;
                end
            end
            HS_TX: begin
                if (tx_done) begin
                    if (hs_ack) begin
                        state_nxt = IDLE;
                        in_done   = 1'b1;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            FAIL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (retry)
            state_nxt = (retry_cnt + 4'd1 == MAX_RETRY) ? FAIL : TOKEN;
    end

    // Packet launch: fires on entry to any transmitting state, using the request as it will be latched.
    always_comb begin
        send_nxt   = (state == IDLE) ? send_in : send_q;
        addr_nxt   = (state == IDLE) ? addr    : addr_q;
        endp_nxt   = (state == IDLE) ? endp    : endp_q;
        launch     = (state_nxt != state) &&
                     (state_nxt == TOKEN || state_nxt == DATA_TX || state_nxt == HS_TX);
        enter_wait = (state_nxt != state) &&
                     (state_nxt == WAIT_HS || state_nxt == WAIT_DATA);
        pid_nxt    = 4'b0000;
        case (state_nxt)
            TOKEN:   pid_nxt = send_nxt ? PID_IN : PID_OUT;
            DATA_TX: pid_nxt = data_pid;
            HS_TX:   pid_nxt = hs_ack_nxt ? PID_ACK : PID_NAK;
            default: pid_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state          <= IDLE;
            retry_cnt      <= 4'd0;
            timer          <= 8'd0;
            hs_ack         <= 1'b0;
            recv_ready_pro <= 1'b0;
            data_up_pro    <= 64'd0;
            tx_start       <= 1'b0;
            tx_pid         <= 4'd0;
            tx_addr        <= 7'd0;
            tx_endp        <= 4'd0;
            tx_data        <= 64'd0;
        end else begin
            state          <= state_nxt;
            hs_ack         <= hs_ack_nxt;
            recv_ready_pro <= in_done;
            tx_start       <= launch;

            if (state == IDLE && input_ready)
                retry_cnt <= 4'd0;
            else if (retry)
                retry_cnt <= retry_cnt + 4'd1;

            if (enter_wait)
                timer <= 8'd0;
            else if (in_wait)
                timer <= timer + 8'd1;

            if (capture)
                data_up_pro <= rx_data;

            if (launch) begin
                tx_pid  <= pid_nxt;
                tx_addr <= addr_nxt;
                tx_endp <= endp_nxt;
                tx_data <= (state_nxt == DATA_TX) ? data_q : 64'd0;
            end
        end
    end

    // Request is captured only in IDLE and held through all retries.
    always_ff @(posedge clk) begin
        if (state == IDLE && input_ready) begin
            send_q <= send_in;
            addr_q <= addr;
            endp_q <= endp;
            data_q <= data_down_pro;
        end
    end

    assign free = (state == IDLE);
    assign bad  = (state == FAIL);

endmodule

// File: tb/tb_usb_protocol.sv
// Directed scoreboard bench for usb_protocol: packet PIDs and IN payloads are queued as expected
// results when stimulus is driven and compared when the DUT emits them.
module tb_usb_protocol;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        input_ready, send_in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data_down_pro;
    logic        tx_done, rx_valid, rx_err;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;
    logic        free, bad, recv_ready_pro, tx_start;
    logic [63:0] data_up_pro, tx_data;
    logic [3:0]  tx_pid, tx_endp;
    logic [6:0]  tx_addr;

    int checks = 0;
    int errors = 0;
    int tx_cnt = 0;
    int out_tok_cnt = 0;
    int bad_cnt = 0;
    logic        tb_tog = 1'b0;
    logic [3:0]  exp_pid[$];
    logic [63:0] exp_data[$];

    usb_protocol dut (
        .clk(clk), .rst_L(rst_L), .input_ready(input_ready), .send_in(send_in),
        .addr(addr), .endp(endp), .data_down_pro(data_down_pro), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_err(rx_err),
        .free(free), .bad(bad), .recv_ready_pro(recv_ready_pro), .data_up_pro(data_up_pro),
        .tx_start(tx_start), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start === 1'b1) begin
            tx_cnt <= tx_cnt + 1;
            if (tx_pid === PID_OUT) out_tok_cnt <= out_tok_cnt + 1;
        end
        if (bad === 1'b1) bad_cnt <= bad_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] data_pid_model();
`ifdef USB_DATA_TOGGLE_EN
        return tb_tog ? PID_DATA1 : PID_DATA0;
`else
        return PID_DATA0;
`endif
    endfunction

    task automatic request(input logic in, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d);
        input_ready = 1'b1; send_in = in; addr = a; endp = e; data_down_pro = d;
        @(negedge clk);
        input_ready = 1'b0;
    endtask

    // Wait for a packet launch, compare its PID with the scoreboard, then play the encoder's tx_done.
    task automatic expect_tx(input string tag);
        int n;
        logic [3:0] e;
        n = 0;
        while (tx_start !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, tx_start, 1'b1);
        e = (exp_pid.size() > 0) ? exp_pid.pop_front() : 4'hF;
        chk({tag, "_pid"}, tx_pid, e);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic rx_send(input logic [3:0] pid, input logic [63:0] d, input logic err);
        rx_valid = 1'b1; rx_pid = pid; rx_data = d; rx_err = err;
        @(negedge clk);
        rx_valid = 1'b0; rx_err = 1'b0;
    endtask

    task automatic ok_out(input string tag, input logic [63:0] d);
        exp_pid.push_back(PID_OUT);
        exp_pid.push_back(data_pid_model());
        request(1'b0, 7'd3, 4'd1, d);
        expect_tx({tag, "_tok"});
        chk({tag, "_txdata"}, tx_data, d);
        expect_tx({tag, "_data"});
        rx_send(PID_ACK, 64'd0, 1'b0);
        tb_tog = ~tb_tog;
        chk({tag, "_free"}, free, 1'b1);
    endtask

    initial begin
        int n, base;
        logic [63:0] e;
        rst_L = 1'b0; input_ready = 1'b0; send_in = 1'b0; addr = '0; endp = '0;
        data_down_pro = '0; tx_done = 1'b0; rx_valid = 1'b0; rx_pid = '0; rx_data = '0;
        rx_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_free", free, 1'b1);
        chk("rst_bad", bad, 1'b0);
        chk("rst_txstart", tx_start, 1'b0);
        chk("rst_txpid", tx_pid, 4'd0);
        chk("rst_dataup", data_up_pro, 64'd0);
        rst_L = 1'b1;
        @(negedge clk);

        // Stray handshake while idle must not start anything.
        base = tx_cnt;
        rx_send(PID_ACK, 64'd0, 1'b0);
        @(negedge clk);
        chk("idle_rx_free", free, 1'b1);
        chk("idle_rx_notx", tx_cnt - base, 0);

        // Plain OUT with immediate ACK.
        exp_pid.push_back(PID_OUT);
        exp_pid.push_back(data_pid_model());
        request(1'b0, 7'd5, 4'd4, 64'hABCD_0000_0000_0000);
        chk("out_free_drop", free, 1'b0);
        expect_tx("out_tok");
        chk("out_txaddr", tx_addr, 7'd5);
        chk("out_txendp", tx_endp, 4'd4);
        chk("out_txdata", tx_data, 64'hABCD_0000_0000_0000);
        expect_tx("out_data");
        rx_send(PID_ACK, 64'd0, 1'b0);
        tb_tog = ~tb_tog;
        chk("out_free", free, 1'b1);
        chk("out_nobad", bad_cnt, 0);

        // IN returning DATA0.
        exp_pid.push_back(PID_IN);
        exp_pid.push_back(PID_ACK);
        request(1'b1, 7'd5, 4'd8, 64'd0);
        expect_tx("in_tok");
        exp_data.push_back(64'h1122334455667788);
        rx_send(PID_DATA0, 64'h1122334455667788, 1'b0);
        expect_tx("in_ack");
        chk("in_rrdy", recv_ready_pro, 1'b1);
        e = exp_data.pop_front();
        chk("in_data", data_up_pro, e);
        @(negedge clk);
        chk("in_rrdy_pulse", recv_ready_pro, 1'b0);
        chk("in_data_held", data_up_pro, e);
        chk("in_free", free, 1'b1);

        // OUT NAKed seven times, ACKed on the eighth attempt.
        base = out_tok_cnt;
        request(1'b0, 7'd9, 4'd2, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 8; i++) begin
            exp_pid.push_back(PID_OUT);
            exp_pid.push_back(data_pid_model());
            expect_tx("nak_tok");
            expect_tx("nak_data");
            rx_send((i < 7) ? PID_NAK : PID_ACK, 64'd0, 1'b0);
        end
        tb_tog = ~tb_tog;
        @(negedge clk);
        chk("nak_tokens", out_tok_cnt - base, 8);
        chk("nak_free", free, 1'b1);
        chk("nak_nobad", bad_cnt, 0);

        // IN with a silent device: eight timeouts, then a one-cycle bad pulse.
        request(1'b1, 7'd1, 4'd1, 64'd0);
        for (int i = 0; i < 8; i++) begin
            exp_pid.push_back(PID_IN);
            expect_tx("to_tok");
            n = 0;
            while (tx_start !== 1'b1 && bad !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("to_wait", n, 201);
        end
        chk("to_bad", bad, 1'b1);
        chk("to_busy", free, 1'b0);
        @(negedge clk);
        chk("to_bad_pulse", bad, 1'b0);
        chk("to_free", free, 1'b1);
        chk("to_badcnt", bad_cnt, 1);

        // IN with a corrupted first DATA: NAK, retry, then accept; a stray request mid-flight is ignored.
        exp_pid.push_back(PID_IN);
        exp_pid.push_back(PID_NAK);
        exp_pid.push_back(PID_IN);
        exp_pid.push_back(PID_ACK);
        request(1'b1, 7'd6, 4'd3, 64'd0);
        expect_tx("err_tok1");
        request(1'b0, 7'd7, 4'd7, 64'hFFFF);
        rx_send(PID_DATA0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        expect_tx("err_nak");
        chk("err_tok2_addr", tx_addr, 7'd6);
        expect_tx("err_tok2");
        exp_data.push_back(64'h5555_AAAA_0F0F_F0F0);
        rx_send(PID_DATA1, 64'h5555_AAAA_0F0F_F0F0, 1'b0);
        expect_tx("err_ack");
        chk("err_rrdy", recv_ready_pro, 1'b1);
        e = exp_data.pop_front();
        chk("err_data", data_up_pro, e);

        // Reset while waiting for a handshake.
        exp_pid.push_back(PID_OUT);
        exp_pid.push_back(data_pid_model());
        request(1'b0, 7'd2, 4'd2, 64'h77);
        expect_tx("rst_tok");
        expect_tx("rst_data");
        rst_L = 1'b0;
        #1;
        chk("midrst_free", free, 1'b1);
        chk("midrst_txstart", tx_start, 1'b0);
        chk("midrst_dataup", data_up_pro, 64'd0);
        tb_tog = 1'b0;
        base = tx_cnt;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_notx", tx_cnt - base, 0);

        // Two back-to-back ACKed OUTs exercise the data toggle when it is built in.
        ok_out("tog1", 64'h1111);
        ok_out("tog2", 64'h2222);

        chk("sb_empty", exp_pid.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_protocol.md
USB_PROTOCOL -- requirements
Module: usb_protocol

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8'd200, handshake/data wait limit in clk cycles.
REQ-002 SHALL have parameter MAX_RETRY, default 4'd8, attempts before a transaction fails.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_L  input  1  reset, asynchronous, active-low.
REQ-005 input_ready  input  1  request valid from read/write FSM; sampled only in IDLE.
REQ-006 send_in  input  1  1=IN transaction, 0=OUT transaction; sampled with input_ready.
REQ-007 addr  input  7  device address; endp  input  4  endpoint; data_down_pro  input  64  OUT payload.
REQ-008 tx_done  input  1  one-cycle pulse: encoder finished current packet.
REQ-009 rx_valid  input  1  one-cycle pulse: decoder delivered a packet; rx_pid  input  4; rx_data  input  64; rx_err  input  1  CRC/stuff error, valid with rx_valid.
REQ-010 free  output  1  high only in IDLE (ready for a request).
REQ-011 bad  output  1  one-cycle pulse: transaction abandoned.
REQ-012 recv_ready_pro  output  1  one-cycle pulse: IN data valid on data_up_pro.
REQ-013 data_up_pro  output  64  registered IN payload, held until next successful IN.
REQ-014 tx_start  output  1  one-cycle pulse launching a packet; tx_pid  output  4; tx_addr  output  7; tx_endp  output  4; tx_data  output  64; tx_* held stable from tx_start until tx_done.

Function
REQ-015 PIDs SHALL be: OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010.
REQ-016 States SHALL be IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, HS_TX, FAIL.
REQ-017 IDLE: on input_ready, latch send_in/addr/endp/data_down_pro, clear retry count, go TOKEN; free drops next cycle.
REQ-018 TOKEN: pulse tx_start on entry with OUT or IN PID; on tx_done go DATA_TX (OUT) or WAIT_DATA (IN).
REQ-019 DATA_TX: pulse tx_start with DATA PID and latched payload; on tx_done go WAIT_HS.
REQ-020 WAIT_HS: rx_valid, !rx_err, rx_pid=ACK -> IDLE (success); NAK, rx_err, other PID, or timeout -> retry.
REQ-021 WAIT_DATA: rx_valid, !rx_err, rx_pid DATA0/DATA1 -> capture rx_data to data_up_pro, go HS_TX sending ACK; rx_err -> HS_TX sending NAK then retry; rx NAK or timeout -> retry.
REQ-022 HS_TX: on tx_done after ACK -> IDLE with recv_ready_pro pulsed in first IDLE cycle; after NAK -> retry.
REQ-023 Retry: increment count; if count reaches MAX_RETRY go FAIL, else go TOKEN.
REQ-024 FAIL: bad=1 and free=0 for exactly one cycle, then IDLE.
REQ-025 Timeout counter SHALL clear on entering WAIT_HS/WAIT_DATA and fire when equal to TIMEOUT_CYC.
REQ-026 rx_valid and timeout in same cycle: rx_valid wins.
REQ-027 rx_valid outside WAIT_HS/WAIT_DATA and input_ready outside IDLE SHALL be ignored.
REQ-028 Latched request SHALL not change during a transaction, including retries.

Reset
REQ-029 On rst_L low: state IDLE, free=1, bad=0, recv_ready_pro=0, tx_start=0, tx_pid/tx_addr/tx_endp/tx_data=0, data_up_pro=0, counters=0, toggle=0.
REQ-030 Reset mid-transaction SHALL abort immediately with no further tx_start.

Configuration
REQ-031 With USB_DATA_TOGGLE_EN defined, DATA_TX SHALL send DATA1 when toggle bit=1; toggle flips on each ACKed OUT; reset 0.
REQ-032 Without USB_DATA_TOGGLE_EN, DATA_TX SHALL always send DATA0 and no toggle state exists; IN accepts DATA0/DATA1 in both builds.

Verification
REQ-033 OUT addr=5 endp=4 data=64'hABCD_0000_0000_0000, encoder acks, device ACK -> tx_pid 0001 then 0011, free high again, no bad.
REQ-034 IN addr=5 endp=8, device returns DATA0 64'h1122334455667788 -> ACK sent, recv_ready_pro pulse, data_up_pro=64'h1122334455667788 held.
REQ-035 OUT with device NAK 7 times then ACK -> 8 TOKEN packets, success, no bad.
REQ-036 IN with no response ever -> 8 timeouts of 200 cycles each, bad one-cycle pulse, then free=1.
REQ-037 IN with rx_err on first DATA -> NAK packet sent, TOKEN retried, second DATA accepted.
REQ-038 rst_L low during WAIT_HS -> free=1, tx_start=0 immediately; with USB_DATA_TOGGLE_EN, two ACKed OUTs send DATA0 then DATA1.
